// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the stereo I2S / left-justified receiver.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_e;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_shift.sv
// Serial-in word assembler: MSB-first shift register with a sample counter.
// done marks the shift that completes a DATA_W-bit word; word is that word.
module i2s_rx_shift #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 6
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_bit,
  input  logic              shift,
  input  logic              din,
  output logic [DATA_W-1:0] word,
  output logic              done
);

  logic [DATA_W-2:0] sr;
  logic [CNT_W-1:0]  bit_cnt;

  assign word = {sr, din};
  assign done = shift && (bit_cnt == CNT_W'(DATA_W - 1));

  // load restarts the count; in left-justified mode the MSB is taken on the load edge
  always_ff @(posedge bclk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= load_bit ? CNT_W'(1) : '0;
      if (load_bit) sr <= word[DATA_W-2:0];
    end else if (shift) begin
      sr      <= word[DATA_W-2:0];
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo serial audio receiver (I2S or left-justified) in the bclk domain.
// Define I2S_RX_SLOT_CHK_EN to enable the short_err slot-length strobe.
//
// state | meaning
// IDLE  | after reset, waiting for the first lrc edge
// DELAY | I2S slot started; the one-bit delay was the slot-start edge, MSB next
// SHIFT | sampling data bits into the word
// HOLD  | word complete; remaining slot bits ignored
module i2s_rx_stereo
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 6
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic              lrc,
  input  logic              adc_din,
  input  logic              mode,
  output logic [DATA_W-1:0] ch_data,
  output logic              ch_id,
  output logic              ch_valid,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              frame_valid,
  output logic              short_err
);

  rx_state_e         state, state_n;
  logic              lrc_q;
  logic              slot_start;
  logic              slot_ch;
  logic              left_done;
  logic              load, load_bit, shift_en, short_det;
  logic              done;
  logic [DATA_W-1:0] word;

  assign slot_start = (lrc != lrc_q);

  i2s_rx_shift #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .bclk    (bclk),
    .rst     (rst),
    .load    (load),
    .load_bit(load_bit),
    .shift   (shift_en),
    .din     (adc_din),
    .word    (word),
    .done    (done)
  );

  always_ff @(posedge bclk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A slot edge always wins, so an LSB landing on the next slot's first edge counts as short
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    short_det = 1'b0;
    if (slot_start) begin
      load      = 1'b1;
      short_det = (state == DELAY) || (state == SHIFT);
      if (mode == MODE_LJ) begin
        load_bit = 1'b1;
        state_n  = SHIFT;
      end else begin
        state_n  = DELAY;
      end
    end else begin
      case (state)
        DELAY: begin
          shift_en = 1'b1;
          state_n  = SHIFT;
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (done) state_n = HOLD;
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      lrc_q       <= 1'b0;
      slot_ch     <= CH_LEFT;
      left_done   <= 1'b0;
      ch_data     <= '0;
      ch_id       <= CH_LEFT;
      ch_valid    <= 1'b0;
      left_data   <= '0;
      right_data  <= '0;
      frame_valid <= 1'b0;
    end else begin
      lrc_q       <= lrc;
      ch_valid    <= 1'b0;
      frame_valid <= 1'b0;
      if (slot_start) slot_ch <= lrc;
      if (short_det) left_done <= 1'b0;
      if (done) begin
        ch_data  <= word;
        ch_id    <= slot_ch;
        ch_valid <= 1'b1;
        if (slot_ch == CH_LEFT) begin
          left_data <= word;
          left_done <= 1'b1;
        end else begin
          right_data  <= word;
          frame_valid <= left_done;
          left_done   <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_SLOT_CHK_EN
  always_ff @(posedge bclk) begin
    if (rst) short_err <= 1'b0;
    else     short_err <= short_det && !short_err;
  end
`else
  assign short_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench for i2s_rx_stereo: a 24-bit instance (A) and a 16-bit instance (B).
module tb_i2s_rx_stereo;

`ifdef I2S_RX_SLOT_CHK_EN
  localparam int EXP_SHORT = 1;
`else
  localparam int EXP_SHORT = 0;
`endif

  logic        bclk, rst;
  logic        lrc_a, din_a, mode_a;
  logic        lrc_b, din_b, mode_b;
  logic [23:0] ch_data_a, left_data_a, right_data_a;
  logic        ch_id_a, ch_valid_a, frame_valid_a, short_err_a;
  logic [15:0] ch_data_b, left_data_b, right_data_b;
  logic        ch_id_b, ch_valid_b, frame_valid_b, short_err_b;

  int checks = 0;
  int errors = 0;

  i2s_rx_stereo #(.DATA_W(24), .CNT_W(6)) dut_a (
    .bclk(bclk), .rst(rst), .lrc(lrc_a), .adc_din(din_a), .mode(mode_a),
    .ch_data(ch_data_a), .ch_id(ch_id_a), .ch_valid(ch_valid_a),
    .left_data(left_data_a), .right_data(right_data_a),
    .frame_valid(frame_valid_a), .short_err(short_err_a)
  );

  i2s_rx_stereo #(.DATA_W(16), .CNT_W(5)) dut_b (
    .bclk(bclk), .rst(rst), .lrc(lrc_b), .adc_din(din_b), .mode(mode_b),
    .ch_data(ch_data_b), .ch_id(ch_id_b), .ch_valid(ch_valid_b),
    .left_data(left_data_b), .right_data(right_data_b),
    .frame_valid(frame_valid_b), .short_err(short_err_b)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one slot; bits past the word (and the I2S delay bit) are driven 1 to show they are ignored.
  task automatic drive_slot(input bit sel, input logic ch, input logic [31:0] word,
                            input int dw, input int slot_len, input logic md,
                            output int nvalid, output int valid_at,
                            output int nframe, output int frame_at, output int nshort);
    logic cv, fv, se;
    nvalid = 0; valid_at = -1; nframe = 0; frame_at = -1; nshort = 0;
    for (int i = 0; i < slot_len; i++) begin
      int   b;
      logic bitv;
      b    = md ? i : i - 1;
      bitv = (b >= 0 && b < dw) ? word[dw-1-b] : 1'b1;
      if (sel) begin lrc_b = ch; mode_b = md; din_b = bitv; end
      else     begin lrc_a = ch; mode_a = md; din_a = bitv; end
      tick();
      cv = sel ? ch_valid_b    : ch_valid_a;
      fv = sel ? frame_valid_b : frame_valid_a;
      se = sel ? short_err_b   : short_err_a;
      if (cv) begin nvalid++; valid_at = i; end
      if (fv) begin nframe++; frame_at = i; end
      if (se) nshort++;
    end
  endtask

  int nv, va, nf, fa, ns, cnt;

  initial begin
    rst = 1'b1;
    lrc_a = 1'b1; din_a = 1'b0; mode_a = 1'b0;
    lrc_b = 1'b0; din_b = 1'b0; mode_b = 1'b1;
    repeat (3) tick();
    check("rst_ch_data",  ch_data_a, 0);
    check("rst_left",     left_data_a, 0);
    check("rst_right",    right_data_a, 0);
    check("rst_flags",    {ch_id_a, ch_valid_a, frame_valid_a, short_err_a}, 0);
    check("rst_b_data",   ch_data_b, 0);
    rst = 1'b0;

    // lrc high at release: first edge is a right slot, no pairing yet
    drive_slot(0, 1'b1, 32'h123456, 24, 32, 1'b0, nv, va, nf, fa, ns);
    check("first_r_valid",   nv, 1);
    check("first_r_at",      va, 24);
    check("first_r_frame",   nf, 0);
    check("first_r_id",      ch_id_a, 1);
    check("first_r_data",    right_data_a, 32'h123456);
    check("first_r_left",    left_data_a, 0);

    // I2S, 32-bit slots
    drive_slot(0, 1'b0, 32'hA5A5A5, 24, 32, 1'b0, nv, va, nf, fa, ns);
    check("i2s_l_valid",  nv, 1);
    check("i2s_l_at",     va, 24);
    check("i2s_l_frame",  nf, 0);
    check("i2s_l_data",   left_data_a, 32'hA5A5A5);
    check("i2s_l_id",     ch_id_a, 0);
    drive_slot(0, 1'b1, 32'h3C3C3C, 24, 32, 1'b0, nv, va, nf, fa, ns);
    check("i2s_r_valid",  nv, 1);
    check("i2s_r_at",     va, 24);
    check("i2s_r_frame",  nf, 1);
    check("i2s_r_frm_at", fa, 24);
    check("i2s_r_data",   right_data_a, 32'h3C3C3C);
    check("i2s_r_ch",     ch_data_a, 32'h3C3C3C);

    // left-justified: one bclk earlier
    drive_slot(0, 1'b0, 32'hA5A5A5, 24, 32, 1'b1, nv, va, nf, fa, ns);
    check("lj_l_at",      va, 23);
    check("lj_l_data",    left_data_a, 32'hA5A5A5);
    drive_slot(0, 1'b1, 32'h3C3C3C, 24, 32, 1'b1, nv, va, nf, fa, ns);
    check("lj_r_at",      va, 23);
    check("lj_r_frame",   nf, 1);
    check("lj_r_data",    right_data_a, 32'h3C3C3C);

    // minimum legal I2S slot (DATA_W+1)
    drive_slot(0, 1'b0, 32'h00FF01, 24, 25, 1'b0, nv, va, nf, fa, ns);
    check("min_l_at",     va, 24);
    check("min_l_data",   left_data_a, 32'h00FF01);
    drive_slot(0, 1'b1, 32'hFFFE80, 24, 25, 1'b0, nv, va, nf, fa, ns);
    check("min_r_short",  ns, 0);
    check("min_r_frame",  nf, 1);
    check("min_r_data",   right_data_a, 32'hFFFE80);

    // 20-bclk left slot: discarded, pairing broken
    drive_slot(0, 1'b0, 32'hFFFFFF, 24, 20, 1'b0, nv, va, nf, fa, ns);
    check("short_valid",  nv, 0);
    check("short_left",   left_data_a, 32'h00FF01);
    check("short_ch",     ch_data_a, 32'hFFFE80);
    drive_slot(0, 1'b1, 32'h0F0F0F, 24, 32, 1'b0, nv, va, nf, fa, ns);
    check("short_err",    ns, EXP_SHORT);
    check("after_s_valid", nv, 1);
    check("after_s_frame", nf, 0);
    check("after_s_data", right_data_a, 32'h0F0F0F);

    // reset in the middle of a left LJ slot
    lrc_a = 1'b0; mode_a = 1'b1; din_a = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_ch",    ch_data_a, 0);
    check("midrst_right", right_data_a, 0);
    check("midrst_flags", {ch_id_a, ch_valid_a, frame_valid_a, short_err_a}, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      din_a = i[0];
      tick();
      if (ch_valid_a) cnt++;
    end
    check("midrst_novalid", cnt, 0);
    drive_slot(0, 1'b1, 32'h654321, 24, 32, 1'b1, nv, va, nf, fa, ns);
    check("post_r_valid", nv, 1);
    check("post_r_frame", nf, 0);
    check("post_r_data",  right_data_a, 32'h654321);
    drive_slot(0, 1'b0, 32'h111111, 24, 32, 1'b1, nv, va, nf, fa, ns);
    drive_slot(0, 1'b1, 32'h222222, 24, 32, 1'b1, nv, va, nf, fa, ns);
    check("post_pair_frame", nf, 1);
    check("post_pair_left",  left_data_a, 32'h111111);

    // 16-bit back-to-back LJ slots
    drive_slot(1, 1'b1, 32'h8001, 16, 16, 1'b1, nv, va, nf, fa, ns);
    check("b_r_at",       va, 15);
    check("b_r_data",     ch_data_b, 32'h8001);
    drive_slot(1, 1'b0, 32'h8001, 16, 16, 1'b1, nv, va, nf, fa, ns);
    check("b_l_short",    ns, 0);
    check("b_l_data",     left_data_b, 32'h8001);
    drive_slot(1, 1'b1, 32'h7FFE, 16, 16, 1'b1, nv, va, nf, fa, ns);
    check("b_r2_short",   ns, 0);
    check("b_r2_frame",   nf, 1);
    check("b_r2_data",    ch_data_b, 32'h7FFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
